// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   ST_IDLE / ST_CALC / ST_DONE : 2-bit binary FSM state encodings
//   DEFAULT_WIDTH               : default operand width
//   prod_width()                : product width for a given operand width
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: A (accumulator), Q (multiplier), M (multiplicand) and C (carry)
// registers plus the conditional adder and right shifter.
//   clk    : system clock
//   reset  : synchronous active-low reset
//   load   : capture m_in/q_in, clear A and C
//   step   : perform one add-and-shift iteration
//   m_in   : multiplicand
//   q_in   : multiplier
//   result : {A,Q} as it will look after the current iteration (2*WIDTH bits)
module mult_datapath
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   step,
    input  logic [WIDTH-1:0]       m_in,
    input  logic [WIDTH-1:0]       q_in,
    output logic [2*WIDTH-1:0]     result
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic             carry;
    logic [WIDTH:0]   sum;

    // The carry register is cleared by every shift, so {carry,acc} is just the
    // zero-extended accumulator; the sum MSB becomes the carry before the shift.
    always_comb begin
        sum = {carry, acc};
        if (mq[0]) begin
            sum = {carry, acc} + {1'b0, mcand};
        end
        result = {sum, mq[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc   <= '0;
            mq    <= '0;
            mcand <= '0;
            carry <= 1'b0;
        end else if (load) begin
            mcand <= m_in;
            mq    <= q_in;
            acc   <= '0;
            carry <= 1'b0;
        end else if (step) begin
            // {C,A,Q} <= {C',A',Q} >> 1 with C' = sum MSB
            carry <= 1'b0;
            acc   <= result[2*WIDTH-1:WIDTH];
            mq    <= result[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-add multiplier with start/busy/done handshake.
// Takes WIDTH iterations per product; back-to-back period is WIDTH+2 cycles.
//   clk     : system clock
//   reset   : synchronous active-low reset
//   start   : begin a multiplication (sampled only in IDLE)
//   m_in    : multiplicand, captured on accepted start
//   q_in    : multiplier (from the Q register), captured on accepted start
//   busy    : high while iterating
//   done    : one-cycle pulse when product becomes valid
//   product : result register, held until the next completion
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH-1:0]              m_in,
    input  logic [WIDTH-1:0]              q_in,
    output logic                          busy,
    output logic                          done,
    output logic [prod_width(WIDTH)-1:0]  product
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = prod_width(WIDTH);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [PW-1:0]    product_next;
    logic [PW-1:0]    result;
    logic             load;
    logic             step;

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .m_in   (m_in),
        .q_in   (q_in),
        .result (result)
    );

    always_comb begin
        state_next   = state;
        count_next   = count;
        product_next = product;
        load         = 1'b0;
        step         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    count_next = CNT_W'(WIDTH);
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                step       = 1'b1;
                count_next = count - 1'b1;
                // Last iteration: latch the post-shift {A,Q} directly
                if (count == CNT_W'(1)) begin
                    product_next = result;
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            product <= '0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            product <= product_next;
        end
    end

    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  m_in;
    logic [7:0]  q_in;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    logic [15:0] exp_q[$];

    seq_shift_add_mult #(
        .WIDTH (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .m_in    (m_in),
        .q_in    (q_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start pulse at a negedge; returns at the negedge after the accept edge.
    task automatic pulse_start(input logic [7:0] m, input logic [7:0] q, input bit push);
        start = 1'b1;
        m_in  = m;
        q_in  = q;
        if (push) exp_q.push_back(16'(m) * 16'(q));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting busy cycles; compare product against the scoreboard.
    task automatic wait_done(input string tag, output int busy_cnt);
        bit seen = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 32'(done), 32'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected_done"}, 32'(done), 32'd0);
        end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check({tag, "_product"}, 32'(product), 32'(e));
            check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int bc;
        int t0;
        int t1;
        int pulses;
        logic [15:0] held;

        reset = 1'b0;
        start = 1'b0;
        m_in  = '0;
        q_in  = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_product", 32'(product), 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic operation and latency
        pulse_start(8'h0D, 8'h0B, 1'b1);
        check("basic_busy_first", 32'(busy), 32'd1);
        wait_done("basic", bc);
        check("basic_busy_cycles", 32'(bc), 32'd8);
        @(negedge clk);
        check("basic_done_one_cycle", 32'(done), 32'd0);
        check("basic_product_hold", 32'(product), 32'h008F);

        // Carry path, alternating pattern, zero operand
        pulse_start(8'hFF, 8'hFF, 1'b1);
        wait_done("ffxff", bc);
        @(negedge clk);
        pulse_start(8'h55, 8'hAA, 1'b1);
        check("alt_product_kept_at_start", 32'(product), 32'hFE01);
        wait_done("55xaa", bc);
        @(negedge clk);
        pulse_start(8'h00, 8'h5A, 1'b1);
        wait_done("zero", bc);
        check("zero_busy_cycles", 32'(bc), 32'd8);
        @(negedge clk);

        // Start re-asserted during CALC is ignored
        pulse_start(8'h0D, 8'h0B, 1'b1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        m_in  = 8'h02;
        q_in  = 8'h03;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", bc);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ignore_no_extra_done", 32'(pulses), 32'd0);

        // Start held high: one product every WIDTH+2 cycles
        start = 1'b1;
        m_in  = 8'h03;
        q_in  = 8'h04;
        for (int k = 0; k < 3; k++) exp_q.push_back(16'h000C);
        @(negedge clk);
        wait_done("held0", bc);
        t0 = cyc;
        @(negedge clk);
        wait_done("held1", bc);
        t1 = cyc;
        check("held_period01", 32'(t1 - t0), 32'd10);
        @(negedge clk);
        wait_done("held2", bc);
        t0 = cyc;
        start = 1'b0;
        check("held_period12", 32'(t0 - t1), 32'd10);
        @(negedge clk);

        // Reset mid-operation discards the result
        @(negedge clk);
        pulse_start(8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'h0);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("abort_no_activity", 32'(pulses), 32'd0);

        // Operands changed right after capture have no effect
        pulse_start(8'h07, 8'h06, 1'b1);
        m_in = 8'hFF;
        q_in = 8'hFF;
        wait_done("late_change", bc);
        held = product;
        @(negedge clk);
        @(negedge clk);
        check("late_change_hold", 32'(product), 32'(held));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Sequential unsigned shift-add multiplier.
- Sits directly downstream of the multiplier-operand Q register in the lab3 multiplier path.
- Consumes the registered multiplier value (Q) and a multiplicand (M). Produces a 2*WIDTH product after WIDTH iterations.
- Provides a start/busy/done handshake to the surrounding lab controller.

Parameters:
- WIDTH, 8, operand width in bits; product width is 2*WIDTH. Legal range 2..32.
- CNT_W, $clog2(WIDTH+1), iteration-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- start  input  1  request to begin a multiplication; sampled only in IDLE.
- m_in  input  WIDTH  multiplicand; captured on the accepted start.
- q_in  input  WIDTH  multiplier, driven from the Q register output; captured on the accepted start.
- busy  output  1  high while iterating (CALC state).
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  2*WIDTH  result register; holds its value until the next completion.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; A, Q, M, C, count = 0.
  - product = 0, busy = 0, done = 0.
  - Reset overrides every other input, including mid-operation; the in-flight result is discarded.
- States: IDLE, CALC, DONE. Binary encoding, 2 bits.
- IDLE:
  - busy=0, done=0.
  - If start==1 at edge T: M<=m_in, Q<=q_in, A<=0, C<=0, count<=WIDTH, go to CALC.
  - Otherwise stay in IDLE.
- CALC (busy=1), one iteration per clock:
  - sum = Q[0] ? ({1'b0,A} + {1'b0,M}) : {1'b0,A}. sum is WIDTH+1 bits; its MSB is the carry C.
  - {C,A,Q} <= {1'b0, sum, Q} >> 1, i.e. A gets sum[WIDTH:1] and Q gets {sum[0], Q[WIDTH-1:1]}.
  - count <= count-1.
  - On the iteration where count==1: product <= the shifted {A,Q} value, go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE unconditionally.
- Latency: start sampled at edge T → done high from edge T+WIDTH to T+WIDTH+1. Product is valid from edge T+WIDTH onward.
- start while in CALC or DONE is ignored; it is not queued.
- start held high continuously: a new operation is accepted on the first IDLE edge. Back-to-back period is WIDTH+2 cycles.
- m_in/q_in changes after capture have no effect on the running operation.
- product is not cleared at start; it keeps the previous result until overwritten at the next DONE entry.
- Operand zero: no early termination; always WIDTH iterations.
- No overflow is possible: max (2^W−1)^2 fits in 2*WIDTH bits.

Decomposition:
- Package mult_pkg:
  - state encoding constants (ST_IDLE=0, ST_CALC=1, ST_DONE=2);
  - default WIDTH constant;
  - product-width helper.
- Sub-module mult_datapath:
  - owns the A/Q/M/C registers and the adder/shifter;
  - controls: load, step;
  - status: result bus.
- The FSM, counter and handshake outputs stay in seq_shift_add_mult.

Test Plan:
- Reset low 2 cycles, then high → product=0x0000, busy=0, done=0. Start pulse m=0x0D, q=0x0B → busy for 8 cycles, done pulse at T+8, product=0x008F.
- m=0xFF, q=0xFF → product=0xFE01 (carry path). Then m=0x55, q=0xAA → product=0x3872. Then m=0x00, q=0x5A → product=0x0000, still 8 busy cycles.
- Start re-asserted during CALC with different operands (0x02,0x03) → ignored; first product (0x0D*0x0B=0x008F) delivered. done pulses exactly once.
- Start held high permanently with m=0x03, q=0x04 → done pulses every 10 cycles; product=0x000C each time.
- Reset driven low at 4th CALC cycle of 0xFF*0xFF → next edge: state IDLE, busy=0, done=0, product=0x0000. No done pulse follows.
- Operands changed on m_in/q_in one cycle after accepted start (0x07*0x06 captured) → product=0x002A.
